// File: rtl/dac_sched_pkg.sv
// Shared types and fade arithmetic for the DAC sample scheduler.
package dac_sched_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        MUTE = 2'd0,
        RUN  = 2'd1,
        FADE = 2'd2
    } sched_state_e;

    // One fade step toward zero; magnitude is 17 bits so -32768 is representable.
    function automatic logic [SAMPLE_W-1:0] fade_step(input logic [SAMPLE_W-1:0] s,
                                                      input int                  shift);
        logic [SAMPLE_W:0] mag;
        logic [SAMPLE_W:0] step;
        mag  = s[SAMPLE_W-1] ? ((SAMPLE_W+1)'(0) - {1'b1, s}) : {1'b0, s};
        step = mag >> shift;
        if (step == '0) begin
            step = (SAMPLE_W+1)'(1);
        end
        if (mag <= step) begin
            fade_step = '0;
        end else if (s[SAMPLE_W-1]) begin
            fade_step = s + step[SAMPLE_W-1:0];
        end else begin
            fade_step = s - step[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every DIV cycles,
// during the last count of each period.
module dac_tick_gen #(
    parameter int DIV = 1515
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/dac_sample_sched.sv
// Per-tick arbiter feeding the DAC register, fading to zero on underrun.
// Sidetone path compiled in only when DAC_SCHED_TONE_EN is defined.
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int CLK_DIV    = 1515,
    parameter int RAMP_SHIFT = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] audio_data,
    input  logic                audio_valid,
    output logic                audio_ready,
    input  logic [SAMPLE_W-1:0] tone_data,
    input  logic                tone_valid,
    output logic                tone_ready,
    input  logic                tone_enable,
    input  logic                underrun_clear,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_tick,
    output logic [7:0]          underrun_count
);

    logic                tick;
    logic                take_tone;
    logic                take_audio;
    logic                have_data;
    logic [SAMPLE_W-1:0] in_data;
    logic [SAMPLE_W-1:0] faded;
    logic                underrun_inc;

    sched_state_e        state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [7:0]          ucnt_q, ucnt_d;

    dac_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (clock),
        .rst_i  (reset),
        .tick_o (tick)
    );

`ifdef DAC_SCHED_TONE_EN
    assign take_tone = tick & tone_enable & tone_valid;
    assign in_data   = take_tone ? tone_data : audio_data;
`else
    logic unused_tone;
    assign unused_tone = ^{tone_data, tone_valid, tone_enable};
    assign take_tone   = 1'b0;
    assign in_data     = audio_data;
`endif

    assign take_audio  = tick & audio_valid & ~take_tone;
    assign have_data   = take_tone | take_audio;
    assign audio_ready = take_audio;
    assign tone_ready  = take_tone;
    assign faded       = fade_step(sample_q, RAMP_SHIFT);

    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        underrun_inc = 1'b0;
        case (state_q)
            MUTE: begin
                sample_d = '0;
                if (have_data) begin
                    sample_d = in_data;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (have_data) begin
                    sample_d = in_data;
                end else if (tick) begin
                    state_d      = FADE;
                    underrun_inc = 1'b1;
                end
            end
            FADE: begin
                if (have_data) begin
                    sample_d = in_data;
                    state_d  = RUN;
                end else if (tick) begin
                    // A zero result means |sample| <= step: snap to rest.
                    sample_d = faded;
                    if (faded == '0) begin
                        state_d = MUTE;
                    end
                end
            end
            default: begin
                sample_d = '0;
                state_d  = MUTE;
            end
        endcase
    end

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_clear) begin
            ucnt_d = '0;
        end else if (underrun_inc && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= MUTE;
            sample_q <= '0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign sample         = sample_q;
    assign sample_tick    = tick;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Randomised and directed bench for dac_sample_sched against a sample-level model.
module tb_dac_sample_sched;

    localparam int DIV = 8;
    localparam int RS  = 6;
`ifdef DAC_SCHED_TONE_EN
    localparam bit TONE_BUILD = 1'b1;
`else
    localparam bit TONE_BUILD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] audio_data = '0;
    logic        audio_valid = 1'b0;
    logic        audio_ready;
    logic [15:0] tone_data = '0;
    logic        tone_valid = 1'b0;
    logic        tone_ready;
    logic        tone_enable = 1'b0;
    logic        underrun_clear = 1'b0;
    logic [15:0] sample;
    logic        sample_tick;
    logic [7:0]  underrun_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: divider position, current DAC word, whether the last tick delivered data.
    int m_cyc = 0;
    int m_smp = 0;
    bit m_stream = 1'b0;
    int m_ucnt = 0;

    bit g_dut_tick;
    bit g_aud_taken;
    bit g_tone_taken;

    always #5 clock = ~clock;

    dac_sample_sched #(
        .CLK_DIV    (DIV),
        .RAMP_SHIFT (RS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .audio_data     (audio_data),
        .audio_valid    (audio_valid),
        .audio_ready    (audio_ready),
        .tone_data      (tone_data),
        .tone_valid     (tone_valid),
        .tone_ready     (tone_ready),
        .tone_enable    (tone_enable),
        .underrun_clear (underrun_clear),
        .sample         (sample),
        .sample_tick    (sample_tick),
        .underrun_count (underrun_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fade(input int s);
        int a;
        int st;
        a  = (s < 0) ? -s : s;
        st = a / (1 << RS);
        if (st < 1) st = 1;
        if (a <= st) return 0;
        return (s < 0) ? s + st : s - st;
    endfunction

    // One clock cycle: drive at negedge, check just after, advance the model.
    task automatic step(input bit av, input logic [15:0] ad, input bit tv,
                        input logic [15:0] td, input bit te, input bit uc);
        bit tick;
        bit tk_tone;
        bit tk_aud;
        bit inc;
        logic [15:0] exp_smp;
        audio_valid    = av;
        audio_data     = ad;
        tone_valid     = tv;
        tone_data      = td;
        tone_enable    = te;
        underrun_clear = uc;
        #1;
        tick    = (m_cyc == DIV - 1);
        tk_tone = TONE_BUILD && tick && te && tv;
        tk_aud  = tick && av && !tk_tone;
        exp_smp = 16'(m_smp);
        check("tick", 32'(sample_tick), 32'(tick));
        check("audio_ready", 32'(audio_ready), 32'(tk_aud));
        check("tone_ready", 32'(tone_ready), 32'(tk_tone));
        check("sample", 32'(sample), 32'(exp_smp));
        check("underrun_count", 32'(underrun_count), 32'(m_ucnt));
        g_dut_tick   = sample_tick;
        g_aud_taken  = tk_aud;
        g_tone_taken = tk_tone;
        inc = 1'b0;
        if (tick) begin
            if (tk_tone || tk_aud) begin
                m_smp    = int'($signed(tk_tone ? td : ad));
                m_stream = 1'b1;
            end else if (m_stream) begin
                m_stream = 1'b0;
                inc      = 1'b1;
            end else begin
                m_smp = ref_fade(m_smp);
            end
        end
        if (uc) m_ucnt = 0;
        else if (inc && m_ucnt < 255) m_ucnt++;
        m_cyc = (m_cyc + 1) % DIV;
        @(negedge clock);
    endtask

    // Run cycles up to and including the next tick; uc is applied only in the tick cycle.
    task automatic period(input bit av, input logic [15:0] ad, input bit tv,
                          input logic [15:0] td, input bit te, input bit uc);
        bit was;
        for (int i = 0; i < DIV; i++) begin
            was = (m_cyc == DIV - 1);
            step(av, ad, tv, td, te, uc && was);
            if (was) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_tick", 32'(sample_tick), 32'd0);
        check("rst_audio_ready", 32'(audio_ready), 32'd0);
        check("rst_tone_ready", 32'(tone_ready), 32'd0);
        check("rst_ucnt", 32'(underrun_count), 32'd0);
        m_cyc = 0; m_smp = 0; m_stream = 1'b0; m_ucnt = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic first_tick_check(input string tag, input logic [15:0] ad);
        int first;
        first = 0;
        for (int i = 1; i <= DIV + 2; i++) begin
            step(1'b1, ad, 1'b0, 16'h0, 1'b0, 1'b0);
            if (g_dut_tick && first == 0) first = i;
        end
        check(tag, 32'(first), 32'(DIV));
    endtask

    task automatic fade_out(input string tag, input logic [15:0] start);
        bit neg;
        bit crossed;
        period(1'b1, start, 1'b0, 16'h0, 1'b0, 1'b0);
        neg = start[15];
        crossed = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            period(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
            if (sample != 16'h0 && sample[15] != neg) crossed = 1'b1;
            if (m_smp == 0 && !m_stream) break;
        end
        check({tag, "_no_cross"}, 32'(crossed), 32'd0);
        check({tag, "_final"}, 32'(sample), 32'd0);
        period(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        a_v, t_v, te, uc;
        logic [15:0] a_d, t_d;
        bit          expect_tone;
        @(negedge clock);
        do_reset();

        first_tick_check("first_tick_cycle", 16'h1234);
        check("first_sample", 32'(sample), 32'h1234);

        // Tone and audio offered on the same tick, then audio alone.
        period(1'b1, 16'h1111, 1'b1, 16'h4000, 1'b1, 1'b0);
        expect_tone = TONE_BUILD;
        step(1'b1, 16'h1111, 1'b0, 16'h4000, 1'b1, 1'b0);
        check("prio_sample", 32'(sample), expect_tone ? 32'h4000 : 32'h1111);
        period(1'b1, 16'h1111, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("audio_after_tone", 32'(sample), 32'h1111);

        fade_out("fade_pos", 16'h0100);
        fade_out("fade_min", 16'h8000);

        for (int k = 0; k < 300; k++) begin
            period(1'b1, 16'(k), 1'b0, 16'h0, 1'b0, 1'b0);
            period(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        end
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("ucnt_saturated", 32'(underrun_count), 32'd255);
        period(1'b1, 16'h0777, 1'b0, 16'h0, 1'b0, 1'b0);
        period(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("clear_wins", 32'(underrun_count), 32'd0);

        // Reset in the middle of a fade with valids held.
        period(1'b1, 16'h4000, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) period(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < DIV - 1; k++) step(1'b1, 16'h2222, 1'b1, 16'h3333, 1'b1, 1'b0);
        do_reset();
        first_tick_check("restart_tick_cycle", 16'h5555);

        a_v = 1'b0; t_v = 1'b0; te = 1'b0; a_d = '0; t_d = '0;
        for (int c = 0; c < 3000; c++) begin
            if (a_v && g_aud_taken) a_v = ($urandom_range(0, 1) == 0);
            else if (!a_v) a_v = ($urandom_range(0, 9) < 2);
            if (a_v && (g_aud_taken || c == 0)) a_d = 16'($urandom);
            if (t_v && g_tone_taken) t_v = 1'b0;
            else if (!t_v) t_v = ($urandom_range(0, 9) == 0);
            if (t_v && g_tone_taken) t_d = 16'($urandom);
            if ($urandom_range(0, 63) == 0) te = ~te;
            if (!t_v) t_d = 16'($urandom);
            uc = ($urandom_range(0, 199) == 0);
            step(a_v, a_d, t_v, t_d, te, uc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Sample-rate scheduler that feeds the 16-bit sigma-delta audio DAC from two requesters: receive audio and an optional CW sidetone. It generates the sample-rate tick from the system clock and arbitrates one sample per tick with valid/ready handshakes. It holds the DAC input register and fades it to zero on underrun, so the DAC never sees a step when the stream stops.

## Interface
- CLK_DIV, 1515, clocks per sample tick (72.728 MHz / 1515 ≈ 48 kHz); legal range 2..65535
- RAMP_SHIFT, 6, fade step divisor exponent (step = |sample| >> RAMP_SHIFT, min 1); legal range 1..15
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- audio_data  in  16  two's-complement audio sample
- audio_valid  in  1  audio_data valid; held until accepted
- audio_ready  out  1  audio sample accepted this cycle when audio_valid is high
- tone_data  in  16  two's-complement sidetone sample
- tone_valid  in  1  tone_data valid; held until accepted
- tone_ready  out  1  tone sample accepted this cycle when tone_valid is high
- tone_enable  in  1  sidetone has priority when high (key down)
- underrun_clear  in  1  synchronous clear of underrun_count
- sample  out  16  two's-complement word to DAC input, registered
- sample_tick  out  1  one-cycle pulse, one per sample period
- underrun_count  out  8  saturating count of underrun events

## Operation
- Divider counts 0..CLK_DIV-1 and wraps. sample_tick is high while count == CLK_DIV-1.
- On tick, arbitration decides:
  - tone_enable && tone_valid: tone_ready=1 and tone_data is taken.
  - Otherwise, audio_valid: audio_ready=1 and audio_data is taken.
  - Otherwise: no data.
- Ready outputs are combinational, high only in the tick cycle and only for the selected source. Both ready outputs are never high together.
- A non-selected source keeps valid asserted and loses no data.
- FSM states:
  - MUTE: sample=0. On a tick with data, load and go to RUN.
  - RUN: on a tick with data, load. On a tick without data, go to FADE and increment underrun_count.
  - FADE: on a tick with data, load and go to RUN. On a tick without data, move sample toward 0 by step; if |sample| <= step, set 0 and go to MUTE.
- Fade arithmetic:
  - |sample| is computed in 17 bits so that -32768 is handled.
  - step = max(|sample| >> RAMP_SHIFT, 1).
  - The result never crosses zero.
- underrun_count saturates at 255. underrun_clear wins over a simultaneous increment.

## Timing
- Reset values: sample=0, sample_tick=0, audio_ready=0, tone_ready=0, underrun_count=0, state=MUTE, divider=0.
- First sample_tick occurs CLK_DIV cycles after reset deasserts.
- Latency: sample and state update on the clock edge that ends the tick cycle (1 cycle). sample is then stable for CLK_DIV cycles.
- tone_enable and valid inputs are sampled only in the tick cycle.
- Reset asserted mid-fade or mid-handshake: all outputs go to reset values immediately. No sample counts as accepted in that cycle.

## Configuration
- DAC_SCHED_TONE_EN defined:
  - Sidetone path and priority logic are compiled in.
- DAC_SCHED_TONE_EN undefined:
  - tone_data, tone_valid and tone_enable are ignored.
  - tone_ready is constant 0.
  - Audio is the sole source.
  - All ports remain present in both builds.

## Structure
- Package dac_sched_pkg holds:
  - SAMPLE_W=16
  - the state enum (MUTE, RUN, FADE)
  - the fade-step function
- Sub-module dac_tick_gen (CLK_DIV counter, sample_tick output) is split out for reuse by other rate-driven blocks.

## Test plan
- CLK_DIV=8; audio_valid held with 16'h1234 from reset -> first tick at cycle 8, audio_ready pulses once, and sample=16'h1234 one cycle later.
- tone_enable=1, tone_valid=1 (16'h4000), audio_valid=1 (16'h1111) on the same tick -> tone_ready=1, audio_ready=0, sample=16'h4000. On the next tick with tone_valid=0, audio is taken and sample=16'h1111.
- RUN with sample=16'h0100, RAMP_SHIFT=6, no data -> underrun_count=1, then successive samples are 0x00FC, 0x00F9, ..., reaching 0 and state MUTE. No sign crossing.
- Fade from 16'h8000 (-32768) -> first step 512 gives 16'h8200, monotonic toward 0, final 0.
- 300 isolated underruns -> underrun_count=255. Pulse underrun_clear on the same cycle as an increment -> 0.
- Reset asserted mid-FADE -> sample=0, readies=0, divider restarts. Build without DAC_SCHED_TONE_EN -> tone_ready stays 0 when tone_enable=1 and tone_valid=1.
